// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-stage constants: default widths, reset vector, instruction size, NOP encoding.
package ifetch_queue_pkg;
  localparam int          ADDR_WIDTH   = 32;
  localparam int          DATA_WIDTH   = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] NOP          = 32'h0000_0013;
endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Registered synchronous FIFO for {pc, instr} pairs; flush empties it in one edge.
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  // Head is forced to zero when empty so stale words never reach decode.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues sequential icache requests, queues results to decode.
module ifetch_queue #(
  parameter int                                       ADDR_WIDTH = ifetch_queue_pkg::ADDR_WIDTH,
  parameter int                                       DATA_WIDTH = ifetch_queue_pkg::DATA_WIDTH,
  parameter int                                       DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]                    RESET_PC   = ADDR_WIDTH'(ifetch_queue_pkg::RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_req,
  input  logic [DATA_WIDTH-1:0] ic_data,
  input  logic                  ic_valid,
  input  logic                  ic_stall,
  output logic                  ic_invalidate,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_fencei,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           miss_cycles
);
  import ifetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]            pc_q, pc_d;
  logic [31:0]                      miss_q, miss_d;
  logic [CW-1:0]                    fifo_count;
  logic                             fifo_empty;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic                             push, pop;

  // Request depends only on registered occupancy, never on out_ready.
  assign ic_req        = !rst && !redirect_valid && (fifo_count < CW'(DEPTH));
  assign ic_addr       = pc_q;
  assign ic_invalidate = !rst && redirect_valid && redirect_fencei;
  assign push          = ic_req && ic_valid;
  assign out_valid     = !fifo_empty;
  assign pop           = out_valid && out_ready;
  assign {out_pc, out_instr} = fifo_head;
  assign miss_cycles   = miss_q;

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, ic_data}),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    else if (push)
      pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
  end

  always_comb begin
    miss_d = miss_q;
    if (ic_req && ic_stall) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      miss_q <= '0;
    end else begin
      pc_q   <= pc_d;
      miss_q <= miss_d;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench: queue-based reference model plus a simple icache model with hits/misses.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rst;
  logic [31:0] ic_addr, ic_data, redirect_pc, out_pc, out_instr, miss_cycles;
  logic        ic_req, ic_valid, ic_stall, ic_invalidate;
  logic        redirect_valid, redirect_fencei, out_valid, out_ready;

  ifetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ic_addr         (ic_addr),
    .ic_req          (ic_req),
    .ic_data         (ic_data),
    .ic_valid        (ic_valid),
    .ic_stall        (ic_stall),
    .ic_invalidate   (ic_invalidate),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_fencei (redirect_fencei),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .miss_cycles     (miss_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pc_m, miss_m;
  int          miss_left, miss_next, miss_prob;
  bit          ready_hit, junk_valid, junk_stall;
  logic [31:0] miss_addr;
  int          checks, failures;

  logic        obs_req, obs_valid, obs_inv;
  logic [31:0] obs_addr, obs_pc, obs_instr, obs_miss;
  logic [130:0] obs_vec, exp_vec;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock: drive inputs at negedge, sample #1 later, then advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit fi, input bit rdy);
    bit   er, v, s, hv;
    int   len;
    ent_t h;
    @(negedge clk);
    er = !r && !rv && (q.size() < DEPTH);
    v = 1'b0;
    s = 1'b0;
    if (!er) begin
      v = junk_valid;
      s = junk_stall;
      if (r || rv) begin
        miss_left = 0;
        ready_hit = 1'b0;
      end
    end else if (miss_left > 0 && miss_addr == pc_m) begin
      s = 1'b1;
      miss_left--;
      if (miss_left == 0) ready_hit = 1'b1;
    end else if (ready_hit && miss_addr == pc_m) begin
      v = 1'b1;
      ready_hit = 1'b0;
    end else begin
      len = miss_next;
      miss_next = 0;
      if (len == 0 && $urandom_range(99) < miss_prob) len = $urandom_range(1, 6);
      if (len > 0) begin
        miss_addr = pc_m;
        s = 1'b1;
        miss_left = len - 1;
        ready_hit = (len == 1);
      end else begin
        v = 1'b1;
      end
    end
    rst = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    redirect_fencei = fi;
    out_ready = rdy;
    ic_valid = v;
    ic_stall = s;
    ic_data = v ? instr_of(pc_m) : $urandom();
    #1;
    obs_req = ic_req; obs_addr = ic_addr; obs_valid = out_valid; obs_pc = out_pc;
    obs_instr = out_instr; obs_miss = miss_cycles; obs_inv = ic_invalidate;
    hv = (q.size() != 0);
    h = hv ? q[0] : '{32'h0, 32'h0};
    exp_vec = {er, pc_m, hv, h.pc, h.instr, miss_m, (!r && rv && fi)};
    obs_vec = {obs_req, obs_addr, obs_valid, hv ? obs_pc : 32'h0, hv ? obs_instr : 32'h0,
               obs_miss, obs_inv};
    if (r) begin
      q.delete();
      pc_m = RESET_PC;
      miss_m = 0;
    end else if (rv) begin
      q.delete();
      pc_m = rpc & ~32'h3;
    end else begin
      if (er && s) miss_m = miss_m + 1;
      if (hv && rdy) void'(q.pop_front());
      if (er && v) begin
        q.push_back('{pc_m, instr_of(pc_m)});
        pc_m = pc_m + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 1);  // DUT state is unknown before the first reset edge
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL reset_cycle %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      checks++;
      if (obs_valid !== 1'b0 || obs_req !== 1'b0 || obs_inv !== 1'b0 || obs_pc !== 32'h0 ||
          obs_instr !== 32'h0 || obs_miss !== 32'h0 || obs_addr !== RESET_PC) begin
        failures++;
        $display("FAIL reset_values got valid=%b req=%b inv=%b pc=%h instr=%h miss=%0d addr=%h want zeros addr=%h",
                 obs_valid, obs_req, obs_inv, obs_pc, obs_instr, obs_miss, obs_addr, RESET_PC);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL stream cyc %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      if (i >= 1) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * (i - 1))) begin
          failures++;
          $display("FAIL stream_order cyc %0d got valid=%b pc=%h want valid=1 pc=%h",
                   i, obs_valid, obs_pc, 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_full();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL full_fill cyc %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_req !== 1'b0 || obs_addr !== 32'h10 || obs_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_hold got req=%b addr=%h head=%h want req=0 addr=00000010 head=0",
               obs_req, obs_addr, obs_pc);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
      failures++;
      $display("FAIL full_resume got req=%b addr=%h want req=1 addr=00000010", obs_req, obs_addr);
    end
    for (int j = 0; j < 6; j++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL push_pop cyc %0d got=%h want=%h", j, obs_vec, exp_vec);
      end
      if (j >= 1) begin
        checks++;
        if (obs_req !== 1'b1 || obs_valid !== 1'b1) begin
          failures++;
          $display("FAIL push_pop_steady cyc %0d got req=%b valid=%b want 1 1", j, obs_req, obs_valid);
        end
      end
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b0) begin
      failures++; $display("FAIL push_pop_count got req=%b want 0 (count stayed 3)", obs_req);
    end
  endtask

  task automatic test_miss();
    logic [31:0] m0;
    int          seen;
    seen = 0;
    m0 = '0;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1);
    miss_next = 6;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 1);
      if (i == 0) m0 = obs_miss;
      if (obs_valid && obs_pc == 32'h40) seen++;
      checks++;
      if (obs_vec !== exp_vec || obs_addr !== 32'h40) begin
        failures++; $display("FAIL miss_hold cyc %0d got=%h want=%h addr=%h", i, obs_vec, exp_vec, obs_addr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1);
      if (obs_valid && obs_pc == 32'h40) seen++;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL miss_after cyc %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      if (i == 0) begin
        checks++;
        if (obs_miss - m0 !== 32'd6) begin
          failures++; $display("FAIL miss_count got delta=%0d want 6", obs_miss - m0);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      failures++; $display("FAIL miss_once got %0d deliveries of pc 0x40 want 1", seen);
    end
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    junk_valid = 1'b1;
    step(0, 1, 32'h1002, 0, 1);
    junk_valid = 1'b0;
    checks++;
    if (obs_vec !== exp_vec || obs_req !== 1'b0) begin
      failures++; $display("FAIL redirect_cycle got=%h want=%h", obs_vec, exp_vec);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (obs_valid !== 1'b0 || obs_addr !== 32'h1000) begin
      failures++;
      $display("FAIL redirect_flush got valid=%b addr=%h want valid=0 addr=00001000", obs_valid, obs_addr);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_valid !== 1'b1 || obs_pc !== 32'h1000) begin
      failures++; $display("FAIL redirect_first got pc=%h valid=%b want pc=00001000 valid=1", obs_pc, obs_valid);
    end
    step(0, 1, 32'hFFFF_FFFE, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_addr !== 32'h0 || obs_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL pc_wrap got addr=%h head=%h want addr=00000000 head=fffffffc", obs_addr, obs_pc);
    end
  endtask

  task automatic test_fencei();
    logic [31:0] m0;
    step(0, 1, 32'h200, 1, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_inv !== 1'b1) begin
      failures++; $display("FAIL fencei_pulse got inv=%b want 1", obs_inv);
    end
    miss_next = 3;
    step(0, 0, 0, 0, 1);
    m0 = obs_miss;
    checks++;
    if (obs_inv !== 1'b0 || obs_addr !== 32'h200 || obs_req !== 1'b1) begin
      failures++;
      $display("FAIL fencei_resume got inv=%b addr=%h req=%b want inv=0 addr=00000200 req=1",
               obs_inv, obs_addr, obs_req);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL fencei_miss cyc %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (obs_miss - m0 !== 32'd3 || obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
      failures++;
      $display("FAIL fencei_first got delta=%0d valid=%b pc=%h want 3 1 00000200", obs_miss - m0, obs_valid, obs_pc);
    end
  endtask

  task automatic test_reset_mid_miss();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    miss_next = 6;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h500, 1, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_inv !== 1'b0 || obs_req !== 1'b0) begin
      failures++; $display("FAIL rst_mid_miss got=%h want=%h", obs_vec, exp_vec);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (obs_addr !== RESET_PC || obs_valid !== 1'b0 || obs_miss !== 32'h0) begin
      failures++;
      $display("FAIL rst_recover got addr=%h valid=%b miss=%0d want addr=%h valid=0 miss=0",
               obs_addr, obs_valid, obs_miss, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          r, rv;
    logic [31:0] rpc;
    miss_prob = 25;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(99) == 0);
      rv  = ($urandom_range(99) < 4);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      junk_valid = $urandom_range(1);
      junk_stall = $urandom_range(1);
      step(r, rv, rpc, $urandom_range(1), $urandom_range(99) < 70);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL random cyc %0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    miss_prob = 0;
    junk_valid = 1'b0;
    junk_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ic_data = '0; ic_valid = 1'b0; ic_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; redirect_fencei = 1'b0; out_ready = 1'b0;
    checks = 0; failures = 0;
    miss_left = 0; miss_next = 0; miss_prob = 0; ready_hit = 1'b0; miss_addr = '0;
    junk_valid = 1'b0; junk_stall = 1'b0;
    pc_m = RESET_PC; miss_m = '0;
    test_reset();
    test_stream();
    test_full();
    test_miss();
    test_redirect();
    test_fencei();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
